echo_delay_fx: RTL
==================

# echo_delay_fx

Parametrised echo engine for the audio codec path: accepts one signed sample per `new_sample_ready` rising edge, mixes it with an attenuated copy from `delay_samples` samples earlier, and returns the result to the codec. Successor to the fixed 200 ms echo. Adds:
- run-time delay length and attenuation shift;
- feed-forward or feedback (repeating) echo;
- signed saturating mix;
- silence until the delay line is primed;
- overrun detection.

## Interface
- `WIDTH`, 16, sample width (two's complement)
- `ADDR_W`, 14, delay-line address width; depth = 2^ADDR_W samples (internal single-port-write / registered-read RAM)
- `SHIFT_W`, 3, width of attenuation shift control

- `clk`  in  1  system clock; one clock domain
- `reset`  in  1  synchronous, active-high reset
- `sample_in`  in  WIDTH  signed input sample; sampled on the accepting cycle
- `new_sample_ready`  in  1  level from codec; each 0->1 transition offers one sample
- `echo_enable`  in  1  1 = add echo term, 0 = pass dry sample
- `feedback_mode`  in  1  0 = RAM stores dry input, 1 = RAM stores mixed output
- `delay_samples`  in  ADDR_W  echo delay in samples; 0 treated as 1
- `echo_shift`  in  SHIFT_W  echo gain = 2^-echo_shift (arithmetic right shift)
- `sample_to_codec`  out  WIDTH  registered mixed sample
- `sample_valid`  out  1  one-cycle pulse when `sample_to_codec` updates
- `primed`  out  1  delay line holds at least `delay_samples` valid entries
- `overrun`  out  1  sticky; a sample edge arrived while busy

## Operation
- Edge detect: register `new_sample_ready` as `rdy_q`. Accept when `new_sample_ready & ~rdy_q & state==IDLE`. On acceptance, latch `sample_in`, `delay_samples` (0->1), `echo_shift`, `echo_enable` and `feedback_mode`.
- FSM: IDLE -> READ -> MIX -> WRITE -> IDLE. No other transitions except reset.
  - READ: drive `rd_addr = wr_ptr - delay` (mod 2^ADDR_W).
  - MIX: RAM data valid. Compute `echo = primed_eff ? (rd_data >>> shift) : 0`, where `primed_eff` is the fill test for this sample. `sum = dry + (echo_en ? echo : 0)` in WIDTH+1 bits. Saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. Register the result to `sample_to_codec` and pulse `sample_valid`.
  - WRITE: write `feedback_mode ? sample_to_codec : dry` to `wr_ptr`, then `wr_ptr <= wr_ptr + 1` (wraps at 2^ADDR_W-1 -> 0).
- Fill counter `fill` (ADDR_W bits, saturating):
  - Increments in WRITE.
  - Cleared to 0 when the latched delay differs from the delay latched for the previous sample.
  - `primed = (fill >= delay)`.
  - The echo term is forced to 0 while not primed, so stale RAM contents are never heard after reset or a delay change.
- `echo_enable=0` bypasses only the mix. RAM writes and the fill counter continue, so re-enabling gives an immediate echo.
- Overrun: a rising edge seen while state != IDLE is dropped and sets `overrun`. Only reset clears it.
- Reset (any state, mid-operation included) next cycle:
  - FSM to IDLE; `wr_ptr`, `fill`, `rdy_q` = 0.
  - All outputs = 0.
  - RAM contents are not cleared; they are masked by `primed`.
  - If `new_sample_ready` is high during reset, no edge is accepted until it falls and rises again.

## Timing
- Cycle A: accepting edge.
- Cycle A+1: READ.
- Cycle A+2: MIX.
- Cycle A+3: `sample_to_codec` valid and `sample_valid`=1 (latency 3 clk from the edge cycle).
- Cycle A+3: RAM write. `wr_ptr` increments at the end of A+3.
- Earliest next acceptance: A+4. Minimum sample spacing is 4 clk.
- `sample_to_codec` holds until the next MIX. `sample_valid` is high exactly 1 cycle per accepted sample.
- `primed` and `overrun` are registered and update at the end of WRITE or the edge cycle respectively.
- Delay wrap: with `wr_ptr`=2 and delay=5, read address = 2^ADDR_W-3.

## Test plan
- Reset then feed-forward, delay=4, shift=1, enable=1, inputs 1000,0,0,0,0,... -> outputs 1000,0,0,0,500,0,...; `primed` rises after 4th write.
- Feedback mode, delay=2, shift=1, input 4000 then zeros -> 4000,0,2000,0,1000,0,500; negative input -4000 -> -2000,-1000 (arithmetic shift).
- Saturation: delay=1, shift=0, inputs 30000,30000 -> 30000,32767; -30000,-30000 -> -30000,-32768.
- Delay change 4->2 mid-stream -> `primed` drops; next 2 outputs dry; echo resumes on the 3rd sample. Run past 2^ADDR_W samples to confirm pointer wrap gives the correct echo.
- Edge 2 cycles after accept -> sample dropped, `overrun`=1 persists, no extra `sample_valid`. Assert `reset` during MIX -> no `sample_valid`, all outputs 0 next cycle.
- `echo_enable` toggled 0->1 after priming -> first enabled output includes the echo of the sample written while disabled.

Source files
------------

// File: rtl/echo_delay_fx.sv
// echo_delay_fx: sample-rate echo engine for the codec path.
// Each accepted sample is mixed with an attenuated copy from `delay_samples`
// samples earlier (feed-forward or feedback), saturated, and returned.
// Pipeline: IDLE (accept) -> READ (address RAM) -> MIX (add, saturate) -> WRITE.
module echo_delay_fx #(
  parameter int WIDTH   = 16,
  parameter int ADDR_W  = 14,
  parameter int SHIFT_W = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [WIDTH-1:0]   sample_in,
  input  logic                      new_sample_ready,
  input  logic                      echo_enable,
  input  logic                      feedback_mode,
  input  logic        [ADDR_W-1:0]  delay_samples,
  input  logic        [SHIFT_W-1:0] echo_shift,
  output logic signed [WIDTH-1:0]   sample_to_codec,
  output logic                      sample_valid,
  output logic                      primed,
  output logic                      overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_MIX   = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t                     r_state;
  logic                       r_rdy_q;
  // Blocks acceptance after reset until new_sample_ready has been seen low.
  logic                       r_blk;
  logic signed [WIDTH-1:0]    r_dry;
  logic signed [WIDTH-1:0]    r_rd_data;
  logic        [ADDR_W-1:0]   r_delay;
  logic        [ADDR_W-1:0]   r_wr_ptr;
  logic        [ADDR_W-1:0]   r_fill;
  logic        [SHIFT_W-1:0]  r_shift;
  logic                       r_echo_en;
  logic                       r_fb;
  logic signed [WIDTH-1:0]    r_mem [0:(1<<ADDR_W)-1];

  logic                       w_edge;
  logic        [ADDR_W-1:0]   w_delay_in;
  logic        [ADDR_W-1:0]   w_rd_addr;
  logic        [ADDR_W-1:0]   w_fill_inc;
  logic signed [WIDTH-1:0]    w_echo;
  logic signed [WIDTH:0]      w_sum;
  logic signed [WIDTH-1:0]    w_mix;
  logic signed [WIDTH-1:0]    w_wr_data;

  // Edge detect, delay sanitising, address and fill arithmetic, saturating mix.
  always_comb begin
    w_edge     = new_sample_ready & ~r_rdy_q & ~r_blk;
    w_delay_in = (delay_samples == {ADDR_W{1'b0}}) ? ADDR_W'(1) : delay_samples;
    w_rd_addr  = r_wr_ptr - r_delay;
    w_fill_inc = (r_fill == {ADDR_W{1'b1}}) ? r_fill : r_fill + ADDR_W'(1);
    w_wr_data  = r_fb ? sample_to_codec : r_dry;
    // Stale RAM contents stay silent until the line holds `delay` fresh entries.
    if (r_echo_en && (r_fill >= r_delay)) begin
      w_echo = r_rd_data >>> r_shift;
    end else begin
      w_echo = {WIDTH{1'b0}};
    end
    w_sum = {r_dry[WIDTH-1], r_dry} + {w_echo[WIDTH-1], w_echo};
    if (w_sum[WIDTH] != w_sum[WIDTH-1]) begin
      w_mix = w_sum[WIDTH] ? SAT_MIN : SAT_MAX;
    end else begin
      w_mix = w_sum[WIDTH-1:0];
    end
  end

  // Delay-line RAM: registered read, single write port, never reset.
  always_ff @(posedge clk) begin
    if (r_state == S_WRITE) begin
      r_mem[r_wr_ptr] <= w_wr_data;
    end
    r_rd_data <= r_mem[w_rd_addr];
  end

  // Sample FSM with registered outputs, fill tracking and overrun flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_rdy_q         <= 1'b0;
      r_blk           <= new_sample_ready;
      r_dry           <= {WIDTH{1'b0}};
      r_delay         <= {ADDR_W{1'b0}};
      r_wr_ptr        <= {ADDR_W{1'b0}};
      r_fill          <= {ADDR_W{1'b0}};
      r_shift         <= {SHIFT_W{1'b0}};
      r_echo_en       <= 1'b0;
      r_fb            <= 1'b0;
      sample_to_codec <= {WIDTH{1'b0}};
      sample_valid    <= 1'b0;
      primed          <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      r_rdy_q      <= new_sample_ready;
      sample_valid <= 1'b0;
      if (!new_sample_ready) begin
        r_blk <= 1'b0;
      end
      if (w_edge && (r_state != S_IDLE)) begin
        overrun <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_edge) begin
            r_dry     <= sample_in;
            r_delay   <= w_delay_in;
            r_shift   <= echo_shift;
            r_echo_en <= echo_enable;
            r_fb      <= feedback_mode;
            // A new delay length invalidates everything already in the line.
            if (w_delay_in != r_delay) begin
              r_fill <= {ADDR_W{1'b0}};
              primed <= 1'b0;
            end
            r_state <= S_READ;
          end
        end
        S_READ: begin
          r_state <= S_MIX;
        end
        S_MIX: begin
          sample_to_codec <= w_mix;
          sample_valid    <= 1'b1;
          r_state         <= S_WRITE;
        end
        S_WRITE: begin
          r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
          r_fill   <= w_fill_inc;
          primed   <= (w_fill_inc >= r_delay);
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
